// File: rtl/zigbee_mode_sequencer.sv
// Mode sequencer for the Zigbee TOP mux/demux selects and the datapath-block reset.
// Optional keep-alive timeout back to MISSION is enabled by defining ZIGBEE_MODE_TIMEOUT_EN.
module zigbee_mode_sequencer #(
    parameter int RST_CYCLES     = 5,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       inClock,
    input  logic       inReset,
    input  logic [2:0] inModeReq,
    input  logic       inModeValid,
    input  logic       inKeepAlive,
    output logic       outBusy,
    output logic       outModeAck,
    output logic       outModeErr,
    output logic [2:0] outModeCur,
    output logic       outBlockRst,
    output logic [2:0] outSEL1,
    output logic [2:0] outSEL2,
    output logic       outSEL3,
    output logic [1:0] outSEL6,
    output logic [1:0] outSEL9,
    output logic       outSEL11,
    output logic       outSEL12,
    output logic [2:0] outSEL15,
    output logic       outSEL17
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam logic [2:0] MODE_MISSION = 3'd0;
    localparam logic [2:0] MODE_ILLEGAL = 3'd7;
    localparam logic [7:0] RST_LOAD     = 8'(RST_CYCLES - 1);
    localparam logic [7:0] SETTLE_LOAD  = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;

    // Packed select word: SEL1, SEL2, SEL3, SEL6, SEL9, SEL11, SEL12, SEL15, SEL17.
    function automatic logic [16:0] sel_lookup(input logic [2:0] mode);
        logic [16:0] sel;
        case (mode)
            3'd1:    sel = {3'b010, 3'b000, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0};
            3'd2:    sel = {3'b001, 3'b001, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 3'b001, 1'b0};
            3'd3:    sel = {3'b000, 3'b111, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1, 3'b001, 1'b0};
            3'd4:    sel = {3'b111, 3'b010, 1'b1, 2'b10, 2'b00, 1'b0, 1'b1, 3'b010, 1'b1};
            3'd5:    sel = {3'b011, 3'b011, 1'b1, 2'b11, 2'b11, 1'b1, 1'b0, 3'b011, 1'b0};
            3'd6:    sel = {3'b100, 3'b100, 1'b1, 2'b11, 2'b11, 1'b1, 1'b1, 3'b011, 1'b0};
            default: sel = {3'b000, 3'b000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0};
        endcase
        return sel;
    endfunction

    state_t      state, state_next;
    logic [7:0]  cnt, cnt_next;
    logic [2:0]  mode_next;
    logic        seq_ack, seq_ack_next;
    logic        err_pend, err_pend_next;
    logic        err_now, err_any;
    logic        ack_next, err_next;
    logic        timeout_hit;
    logic [16:0] sel_reg;

`ifdef ZIGBEE_MODE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer, timer_next;

    // Idle timer only runs while a test mode is live and no keep-alive arrives.
    always_comb begin
        timer_next  = '0;
        timeout_hit = 1'b0;
        if (state == RUN && outModeCur != MODE_MISSION && !inKeepAlive) begin
            timer_next = timer + 1'b1;
            if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                timeout_hit = 1'b1;
            end
        end
    end
`else
    logic unused_keep_alive;
    assign unused_keep_alive = inKeepAlive ^ (TIMEOUT_CYCLES == 0);
    assign timeout_hit       = 1'b0;
`endif

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        mode_next    = outModeCur;
        seq_ack_next = seq_ack;
        ack_next     = 1'b0;
        err_now      = 1'b0;
        case (state)
            RUN: begin
                if (inModeValid) begin
                    if (inModeReq == MODE_ILLEGAL) begin
                        err_now = 1'b1;
                    end else begin
                        mode_next    = inModeReq;
                        cnt_next     = RST_LOAD;
                        state_next   = HOLD;
                        seq_ack_next = 1'b1;
                    end
                end else if (timeout_hit) begin
                    mode_next    = MODE_MISSION;
                    cnt_next     = RST_LOAD;
                    state_next   = HOLD;
                    seq_ack_next = 1'b0;
                    err_now      = 1'b1;
                end
            end
            HOLD: begin
                err_now = inModeValid;
                if (cnt == 8'd0) begin
                    if (SETTLE_CYCLES == 0) begin
                        state_next = RUN;
                        ack_next   = seq_ack;
                    end else begin
                        state_next = SETTLE;
                        cnt_next   = SETTLE_LOAD;
                    end
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            SETTLE: begin
                err_now = inModeValid;
                if (cnt == 8'd0) begin
                    state_next = RUN;
                    ack_next   = seq_ack;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            default: begin
                state_next = HOLD;
                cnt_next   = RST_LOAD;
                mode_next  = MODE_MISSION;
            end
        endcase
        // A drop that lands on the ack cycle is deferred one cycle so ack and err never overlap.
        err_any       = err_now | err_pend;
        err_next      = err_any & ~ack_next;
        err_pend_next = err_any & ack_next;
    end

    always_ff @(posedge inClock) begin
        if (inReset) begin
            state       <= HOLD;
            cnt         <= RST_LOAD;
            seq_ack     <= 1'b0;
            err_pend    <= 1'b0;
            outModeCur  <= MODE_MISSION;
            outBusy     <= 1'b1;
            outBlockRst <= 1'b1;
            outModeAck  <= 1'b0;
            outModeErr  <= 1'b0;
            sel_reg     <= sel_lookup(MODE_MISSION);
`ifdef ZIGBEE_MODE_TIMEOUT_EN
            timer       <= '0;
`endif
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            seq_ack     <= seq_ack_next;
            err_pend    <= err_pend_next;
            outModeCur  <= mode_next;
            outBusy     <= (state_next != RUN);
            outBlockRst <= (state_next == HOLD);
            outModeAck  <= ack_next;
            outModeErr  <= err_next;
            sel_reg     <= sel_lookup(mode_next);
`ifdef ZIGBEE_MODE_TIMEOUT_EN
            timer       <= timer_next;
`endif
        end
    end

    assign {outSEL1, outSEL2, outSEL3, outSEL6, outSEL9,
            outSEL11, outSEL12, outSEL15, outSEL17} = sel_reg;

endmodule
